// File: rtl/mult_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// step count and the partial-product select encoding.
package mult_pkg;

    localparam int OP_W       = 32;
    localparam int PROD_W     = 64;
    localparam int MULT_STEPS = 16;
    localparam int STEP_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Partial product selected by one Booth triplet.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_sel_t;

    function automatic logic sel_is_neg(input booth_sel_t sel);
        return (sel == NEG1) || (sel == NEG2);
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: multiplier triplet {b[i+1], b[i], b[i-1]} to select.
// Latency: combinational.
// Backpressure: none.
module booth_recode
    import mult_pkg::*;
(
    input  logic [2:0] triplet,
    output logic [2:0] sel
);

    booth_sel_t sel_e;

    always_comb begin
        sel_e = ZERO;
        unique case (triplet)
            3'b000, 3'b111: sel_e = ZERO;
            3'b001, 3'b010: sel_e = POS1;
            3'b011:         sel_e = POS2;
            3'b100:         sel_e = NEG2;
            3'b101, 3'b110: sel_e = NEG1;
            default:        sel_e = ZERO;
        endcase
    end

    assign sel = sel_e;

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential signed 32x32 multiplier, radix-4 Booth, 2 multiplier bits per cycle.
// Latency: result strobe in the cycle after the 16th RUN edge following the start edge.
// Backpressure: none; a new start pulse aborts and restarts any operation in flight.
module mult_booth_seq
    import mult_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    state_t              state;
    state_t              state_nx;
    logic                load_result;

    logic [OP_W-1:0]     a_reg;
    logic [OP_W:0]       b_reg;
    logic [PROD_W-1:0]   acc;
    logic [STEP_W-1:0]   step;

    logic [2:0]          sel_bits;
    booth_sel_t          sel;
    logic                sel_neg;
    logic [PROD_W-1:0]   a_ext;
    logic [PROD_W-1:0]   mag;
    logic [PROD_W-1:0]   mag_sh;
    logic [PROD_W-1:0]   addend;
    logic [PROD_W-1:0]   sum;
    logic                sum_ovf;

    booth_recode u_recode (
        .triplet (b_reg[2:0]),
        .sel     (sel_bits)
    );

    assign sel = booth_sel_t'(sel_bits);

    // Subtraction reuses the single adder as acc + ~x + 1.
    always_comb begin
        a_ext   = {{(PROD_W-OP_W){a_reg[OP_W-1]}}, a_reg};
        mag     = '0;
        unique case (sel)
            POS1, NEG1: mag = a_ext;
            POS2, NEG2: mag = a_ext << 1;
            default:    mag = '0;
        endcase
        mag_sh  = mag << {step, 1'b0};
        sel_neg = sel_is_neg(sel);
        addend  = sel_neg ? ~mag_sh : mag_sh;
        sum     = acc + addend + {{(PROD_W-1){1'b0}}, sel_neg};
        sum_ovf = ~((&sum[PROD_W-1:OP_W-1]) | ~(|sum[PROD_W-1:OP_W-1]));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        load_result = 1'b0;
        unique case (state)
            IDLE: state_nx = IDLE;
            RUN: begin
                if (step == STEP_W'(MULT_STEPS - 1)) begin
                    state_nx    = DONE;
                    load_result = 1'b1;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // A start pulse wins from any state and kills a pending result load.
        if (ctrl_MULT) begin
            state_nx    = RUN;
            load_result = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg          <= '0;
            b_reg          <= '0;
            acc            <= '0;
            step           <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (ctrl_MULT) begin
            a_reg          <= data_operandA;
            b_reg          <= {data_operandB, 1'b0};
            acc            <= '0;
            step           <= '0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= load_result;
            if (state == RUN) begin
                acc   <= sum;
                b_reg <= $signed(b_reg) >>> 2;
                step  <= step + 1'b1;
            end
            if (load_result) begin
                data_result    <= sum[OP_W-1:0];
                data_exception <= sum_ovf;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed and model-checked vectors for the sequential Booth multiplier.
module tb_mult_booth_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mult_booth_seq dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the result strobe; lat counts edges after the start edge.
    task automatic wait_rdy(output int lat);
        lat = 99;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_exc);
        int lat;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        wait_rdy(lat);
        chk({tag, "_lat"},  64'(lat), 64'd16);
        chk({tag, "_res"},  64'(data_result), 64'(exp_res));
        chk({tag, "_exc"},  64'(data_exception), 64'(exp_exc));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        @(posedge clock);
        #1;
        chk({tag, "_rdy_off"},  64'(data_resultRDY), 64'd0);
        chk({tag, "_idle"},     64'(busy), 64'd0);
    endtask

    logic [31:0]        ra, rb;
    logic signed [63:0] prod;
    int                 lat;
    int                 pulses;

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_res",  64'(data_result), 64'd0);
        chk("rst_exc",  64'(data_exception), 64'd0);
        chk("rst_rdy",  64'(data_resultRDY), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        do_mult("m3x5",      32'd3,          32'd5,          32'd15,         1'b0);
        do_mult("mneg1xmin", 32'hFFFF_FFFF,  32'h8000_0000,  32'h8000_0000,  1'b1);
        do_mult("mminx1",    32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0);
        do_mult("mmaxx2",    32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1);
        do_mult("mn7x6",     32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFD6,  1'b0);
        do_mult("m0xmin",    32'd0,          32'h8000_0000,  32'd0,          1'b0);
        do_mult("mminxmin",  32'h8000_0000,  32'h8000_0000,  32'd0,          1'b1);
        do_mult("mn1xn1",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0);
        do_mult("m2p16sq",   32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1);
        do_mult("mmaxsq",    32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd1,          1'b1);

        // Restart at step 8: only the 4*4 result may be reported.
        @(negedge clock);
        data_operandA = 32'd3;
        data_operandB = 32'd5;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (8) @(negedge clock);
        data_operandA = 32'd4;
        data_operandB = 32'd4;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        wait_rdy(lat);
        chk("restart_lat", 64'(lat), 64'd16);
        chk("restart_res", 64'(data_result), 64'd16);
        chk("restart_exc", 64'(data_exception), 64'd0);
        pulses = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        chk("restart_extra_rdy", 64'(pulses), 64'd0);

        // Start held high for three edges: the last sampled operands win.
        @(negedge clock);
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        data_operandA = 32'd2;
        data_operandB = 32'd3;
        @(negedge clock);
        data_operandA = 32'd6;
        data_operandB = 32'd7;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        wait_rdy(lat);
        chk("hold_lat", 64'(lat), 64'd16);
        chk("hold_res", 64'(data_result), 64'd42);

        // Reset mid-RUN: outputs cleared, no strobe afterwards.
        @(negedge clock);
        data_operandA = 32'd3;
        data_operandB = 32'd5;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_res",  64'(data_result), 64'd0);
        chk("midrst_exc",  64'(data_exception), 64'd0);
        chk("midrst_rdy",  64'(data_resultRDY), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (data_resultRDY || busy) pulses++;
        end
        chk("midrst_quiet", 64'(pulses), 64'd0);

        // Reset beats a simultaneous start.
        @(negedge clock);
        reset     = 1'b1;
        ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_prio_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_prio_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 1500; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = 32'($signed(ra) >>> 20);
            if (i % 4 == 2) rb = 32'($signed(rb) >>> 18);
            prod = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
            do_mult("rand", ra, rb, prod[31:0],
                    !((&prod[63:31]) || !(|prod[63:31])));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
